// File: rtl/concat_pkg.sv
// Shared types and width helpers for the bit-field packer family.
// Width functions let parameter defaults derive port widths from the field and word sizes.
package concat_pkg;

  typedef enum logic [0:0] {
    ACCUM      = 1'b0,
    FLUSH_PEND = 1'b1
  } state_t;

  function automatic int len_width(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  function automatic int cnt_width(input int out_w);
    return $clog2(out_w + 1);
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/concat_merge.sv
// Combinational append of a masked field below a right-aligned accumulator.
// Produces the left-aligned word candidate, the right-aligned remainder and the new count.
module concat_merge
  import concat_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int LEN_W = len_width(IN_W),
  parameter int CNT_W = cnt_width(OUT_W)
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [CNT_W-1:0] cnt,
  input  logic [IN_W-1:0]  data,
  input  logic [LEN_W-1:0] len,
  output logic             full,
  output logic [OUT_W-1:0] word,
  output logic [CNT_W-1:0] word_bits,
  output logic [OUT_W-1:0] rem,
  output logic [CNT_W-1:0] rem_cnt
);

  localparam int CAT_W = OUT_W + IN_W;
  localparam int TOT_W = CNT_W + 1;

  logic [LEN_W-1:0] len_c;
  logic [IN_W-1:0]  field;
  logic [CAT_W-1:0] cat;
  logic [TOT_W-1:0] tot;
  logic [TOT_W-1:0] over;

  // Build the joined bit string and split it into word / remainder
  always_comb begin
    len_c = LEN_W'(clamp_len(int'(len), IN_W));
    field = data & ~({IN_W{1'b1}} << len_c);
    cat   = ({{IN_W{1'b0}}, acc} << len_c) | {{OUT_W{1'b0}}, field};
    tot   = TOT_W'(cnt) + TOT_W'(len_c);
    over  = tot - TOT_W'(OUT_W);
    if (tot >= TOT_W'(OUT_W)) begin
      full      = 1'b1;
      word      = OUT_W'(cat >> over);
      word_bits = CNT_W'(OUT_W);
      rem       = OUT_W'(cat) & ~({OUT_W{1'b1}} << over);
      rem_cnt   = CNT_W'(over);
    end else begin
      // Partial result: left-align and zero-pad for a possible flush
      full      = 1'b0;
      word      = OUT_W'(cat << (TOT_W'(OUT_W) - tot));
      word_bits = CNT_W'(tot);
      rem       = OUT_W'(cat);
      rem_cnt   = CNT_W'(tot);
    end
  end

endmodule

// File: rtl/concat_packer.sv
// Packs variable-length fields MSB-first into OUT_W-bit words with valid/ready on both sides.
// A flush emits a partial word zero-padded; an overflowing flush owes one extra word.
module concat_packer
  import concat_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int LEN_W = len_width(IN_W),
  parameter int CNT_W = cnt_width(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_bits
);

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             slot_free;
  logic             take;
  logic [LEN_W-1:0] merge_len;
  logic             m_full;
  logic [OUT_W-1:0] m_word;
  logic [CNT_W-1:0] m_bits;
  logic [OUT_W-1:0] m_rem;
  logic [CNT_W-1:0] m_rem_cnt;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == ACCUM) && slot_free && !rst;
  assign take      = in_ready && (in_valid || flush);
  // With a zero length the merge yields the padded accumulator, reused for plain and pending flushes
  assign merge_len = ((state == ACCUM) && in_valid) ? in_len : {LEN_W{1'b0}};

  concat_merge #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) u_merge (
    .acc      (acc),
    .cnt      (cnt),
    .data     (in_data),
    .len      (merge_len),
    .full     (m_full),
    .word     (m_word),
    .word_bits(m_bits),
    .rem      (m_rem),
    .rem_cnt  (m_rem_cnt)
  );

  // Packer FSM, accumulator and registered output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= {OUT_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_bits  <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ACCUM: begin
          if (take) begin
            if (m_full) begin
              out_valid <= 1'b1;
              out_data  <= m_word;
              out_bits  <= m_bits;
              acc       <= m_rem;
              cnt       <= m_rem_cnt;
              if (flush && (m_rem_cnt != {CNT_W{1'b0}})) begin
                state <= FLUSH_PEND;
              end
            end else if (flush && (m_bits != {CNT_W{1'b0}})) begin
              out_valid <= 1'b1;
              out_data  <= m_word;
              out_bits  <= m_bits;
              acc       <= {OUT_W{1'b0}};
              cnt       <= {CNT_W{1'b0}};
            end else begin
              acc <= m_rem;
              cnt <= m_rem_cnt;
            end
          end
        end
        FLUSH_PEND: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_data  <= m_word;
            out_bits  <= m_bits;
            acc       <= {OUT_W{1'b0}};
            cnt       <= {CNT_W{1'b0}};
            state     <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_concat_packer.sv
// Directed bench for concat_packer (IN_W=8, OUT_W=16) with an output scoreboard.
module tb_concat_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [3:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_bits;

  int passed = 0;
  int total  = 0;
  logic [20:0] sb[$];

  concat_packer #(.IN_W(8), .OUT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_bits (out_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [4:0] b);
    sb.push_back({b, d});
  endtask

  // Present one beat (field and/or flush) and hold it until accepted
  task automatic send(input logic [7:0] d, input logic [3:0] l, input logic v, input logic f);
    int waited;
    waited   = 0;
    in_valid = v;
    in_data  = d;
    in_len   = l;
    flush    = f;
    #1;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = 8'h00;
    in_len   = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: pop and compare each consumed word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {16'd0, out_data}, 32'hDEAD);
      end else begin
        logic [20:0] e;
        e = sb.pop_front();
        check("out_data", {16'd0, out_data}, {16'd0, e[15:0]});
        check("out_bits", {27'd0, out_bits}, {27'd0, e[20:16]});
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_len    = 4'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_bits", {27'd0, out_bits}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Exact fill; word appears the cycle after the third accept
    expect_word(16'hABCD, 5'd16);
    send(8'h0A, 4'd4, 1'b1, 1'b0);
    send(8'hBC, 4'd8, 1'b1, 1'b0);
    send(8'h0D, 4'd4, 1'b1, 1'b0);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    idle(2);

    // Overflow then standalone flush of the 4-bit remainder
    expect_word(16'hABCF, 5'd16);
    expect_word(16'hF000, 5'd4);
    send(8'h0A, 4'd4, 1'b1, 1'b0);
    send(8'hBC, 4'd8, 1'b1, 1'b0);
    send(8'hFF, 4'd8, 1'b1, 1'b0);
    send(8'h00, 4'd0, 1'b0, 1'b1);
    idle(2);

    // Zero length, clamped length, garbage above in_len
    expect_word(16'hA53C, 5'd16);
    send(8'hFF, 4'd0, 1'b1, 1'b0);
    send(8'hA5, 4'd15, 1'b1, 1'b0);
    send(8'h3C, 4'd8, 1'b1, 1'b0);
    expect_word(16'hBFFF, 5'd16);
    send(8'hFD, 4'd3, 1'b1, 1'b0);
    send(8'hFF, 4'd8, 1'b1, 1'b0);
    send(8'hFF, 4'd5, 1'b1, 1'b0);
    idle(2);

    // Backpressure holds the word and blocks input
    out_ready = 1'b0;
    expect_word(16'h1234, 5'd16);
    send(8'h12, 4'd8, 1'b1, 1'b0);
    send(8'h34, 4'd8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_data", {16'd0, out_data}, 32'h1234);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      idle(1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    idle(2);

    // Flush together with an overflowing field: two back-to-back words
    expect_word(16'hABCF, 5'd16);
    expect_word(16'hF000, 5'd4);
    send(8'h0A, 4'd4, 1'b1, 1'b0);
    send(8'hBC, 4'd8, 1'b1, 1'b0);
    send(8'hFF, 4'd8, 1'b1, 1'b1);
    check("pend_in_ready", {31'd0, in_ready}, 32'd0);
    idle(1);
    check("pend_second_data", {16'd0, out_data}, 32'hF000);
    check("pend_second_bits", {27'd0, out_bits}, 32'd4);
    idle(2);

    // Asynchronous reset while a word and a pending flush are held
    out_ready = 1'b0;
    send(8'h0A, 4'd4, 1'b1, 1'b0);
    send(8'hBC, 4'd8, 1'b1, 1'b0);
    send(8'hFF, 4'd8, 1'b1, 1'b1);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_bits", {27'd0, out_bits}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    idle(2);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    send(8'h00, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("empty_flush_valid", {31'd0, out_valid}, 32'd0);
      idle(1);
    end
    expect_word(16'hABCD, 5'd16);
    send(8'h0A, 4'd4, 1'b1, 1'b0);
    send(8'hBC, 4'd8, 1'b1, 1'b0);
    send(8'h0D, 4'd4, 1'b1, 1'b0);
    idle(4);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
